// File: rtl/apb_completer_bank.sv
// APB completer bank: NUM_SLV independent DEPTH-word banks with wait states and PSLVERR; APB_PSTRB_EN adds byte strobes.
// PREADY in ACCESS cycle WAIT_STATES+1; requester holds the transfer until PREADY, and dropping all PSELx aborts it.
module apb_completer_bank #(
    parameter int NUM_SLV     = 3,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [NUM_SLV-1:0]  PSELx,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0] PSTRB,
`endif
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int NB   = DATA_W / 8;
    localparam int BO   = $clog2(NB);
    localparam int WI_W = $clog2(DEPTH);
    localparam int SI_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SI_W-1:0]     slv_q, slv_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
`ifdef APB_PSTRB_EN
    logic [NB-1:0]       strb_q, strb_d;
`endif

    logic [DATA_W-1:0]   mem_q [NUM_SLV][DEPTH];

    logic [SI_W-1:0]     sel_idx;
    logic                sel_multi;
    logic                setup_err;
    logic                chg;
    logic [SI_W-1:0]     ld_slv;
    logic [ADDR_W-1:0]   ld_addr;
    logic                ld_write;
    logic                ld_err;
    logic [WI_W-1:0]     ld_word;
    logic [DATA_W-1:0]   ld_rdata;
    logic [WI_W-1:0]     wr_word;
    logic [DATA_W-1:0]   wr_merged;
    logic                we;

    // Lowest set bit wins; a multi-hot select is flagged as an error anyway.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (PSELx[i]) sel_idx = SI_W'(i);
        end
    end

    assign sel_multi = (PSELx & (PSELx - 1'b1)) != '0;
    assign setup_err = sel_multi || ((PADDR >> (BO + WI_W)) != '0);
    assign chg       = (PADDR != addr_q) || (PWRITE != write_q) || (PWDATA != wdata_q);

    // Response is sourced from live inputs at SETUP, from the captured copy during ACCESS.
    always_comb begin
        if (state_q == IDLE) begin
            ld_slv   = sel_idx;
            ld_addr  = PADDR;
            ld_write = PWRITE;
            ld_err   = setup_err;
        end else begin
            ld_slv   = slv_q;
            ld_addr  = addr_q;
            ld_write = write_q;
            ld_err   = err_q || chg;
        end
        ld_word  = ld_addr[BO+WI_W-1:BO];
        ld_rdata = (ld_write || ld_err) ? '0 : mem_q[ld_slv][ld_word];
    end

    assign wr_word = addr_q[BO+WI_W-1:BO];

    always_comb begin
        wr_merged = wdata_q;
`ifdef APB_PSTRB_EN
        for (int b = 0; b < NB; b++) begin
            if (!strb_q[b]) wr_merged[b*8 +: 8] = mem_q[slv_q][wr_word][b*8 +: 8];
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        slv_d     = slv_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
`ifdef APB_PSTRB_EN
        strb_d    = strb_q;
`endif
        we        = 1'b0;
        case (state_q)
            IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
                if (|PSELx && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_STATES);
                    addr_d  = PADDR;
                    slv_d   = sel_idx;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    err_d   = setup_err;
`ifdef APB_PSTRB_EN
                    strb_d  = PSTRB;
`endif
                    if (WAIT_STATES == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = ld_err;
                        prdata_d  = ld_rdata;
                    end
                end
            end
            ACCESS: begin
                err_d = err_q || chg;
                if (PSELx == '0) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (pready_q && PENABLE && PSELx[slv_q]) begin
                    we        = write_q && !(err_q || chg);
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = ld_err;
                        prdata_d  = ld_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            slv_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
`ifdef APB_PSTRB_EN
            strb_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            slv_q     <= slv_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
`ifdef APB_PSTRB_EN
            strb_q    <= strb_d;
`endif
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int s = 0; s < NUM_SLV; s++) begin
                for (int w = 0; w < DEPTH; w++) begin
                    mem_q[s][w] <= '0;
                end
            end
        end else if (we) begin
            mem_q[slv_q][wr_word] <= wr_merged;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_completer_bank.sv
// Bench for apb_completer_bank: one instance with no wait states, one with three; responses checked from a queue.
module tb_apb_completer_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  psel   [2];
    logic        pen    [2];
    logic        pwr    [2];
    logic [31:0] paddr  [2];
    logic [31:0] pwdata [2];
    logic [31:0] prdata [2];
    logic        pready [2];
    logic        pslverr[2];
`ifdef APB_PSTRB_EN
    logic [3:0]  pstrb  [2];
`endif

    int ws[2] = '{0, 3};

    apb_completer_bank #(.NUM_SLV(3), .DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
        .PCLK(clk), .PRESET(rst), .PSELx(psel[0]), .PENABLE(pen[0]), .PWRITE(pwr[0]),
        .PADDR(paddr[0]), .PWDATA(pwdata[0]),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb[0]),
`endif
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_completer_bank #(.NUM_SLV(3), .DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_STATES(3)) u_ws3 (
        .PCLK(clk), .PRESET(rst), .PSELx(psel[1]), .PENABLE(pen[1]), .PWRITE(pwr[1]),
        .PADDR(paddr[1]), .PWDATA(pwdata[1]),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb[1]),
`endif
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    typedef struct {
        int          d;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: every PREADY cycle consumes one expected response; otherwise outputs must be 0.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (pready[d]) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pready dut%0d got rdata=%h err=%0b want no response", d, prdata[d], pslverr[d]);
                    end else begin
                        e = sb.pop_front();
                        if (e.d != d || prdata[d] !== e.rd || pslverr[d] !== e.err) begin
                            errors++;
                            $display("FAIL response dut%0d got rdata=%h err=%0b want dut%0d rdata=%h err=%0b",
                                     d, prdata[d], pslverr[d], e.d, e.rd, e.err);
                        end
                    end
                end else if (prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs dut%0d got rdata=%h err=%0b want 0 0", d, prdata[d], pslverr[d]);
                end
            end
        end
    end

    // Leaves the request asserted; the next call's first edge is the completion edge.
    task automatic xfer(input int d, input logic [2:0] sel, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [3:0] strb, input logic [31:0] erd, input logic eerr);
        int   n;
        exp_t e;
        @(posedge clk); #1;
        psel[d] = sel; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = addr; pwdata[d] = wd;
`ifdef APB_PSTRB_EN
        pstrb[d] = strb;
`else
        if (strb === 4'hx) $display("strobe unused");
`endif
        e.d = d; e.rd = erd; e.err = eerr;
        sb.push_back(e);
        @(posedge clk); #1;
        pen[d] = 1'b1;
        n = 1;
        while (1) begin
            @(negedge clk);
            if (pready[d] || n >= 40) break;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != ws[d] + 1) begin
            errors++;
            $display("FAIL latency dut%0d addr=%h got %0d access cycles want %0d", d, addr, n, ws[d] + 1);
        end
    endtask

    task automatic idle(input int d);
        @(posedge clk); #1;
        psel[d] = 3'b000; pen[d] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            psel[d] = '0; pen[d] = 1'b0; pwr[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
`ifdef APB_PSTRB_EN
            pstrb[d] = 4'hF;
`endif
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic write/read, no wait states
        xfer(0, 3'b010, 32'h8,  1'b1, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
        xfer(0, 3'b010, 32'h8,  1'b0, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
        xfer(0, 3'b010, 32'h9,  1'b0, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
        xfer(0, 3'b001, 32'h8,  1'b0, 32'h0,        4'hF, 32'h0,        1'b0);
        // Errors: out of range, multi-hot select
        xfer(0, 3'b001, 32'h40, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1);
        xfer(0, 3'b001, 32'h44, 1'b0, 32'h0,        4'hF, 32'h0,        1'b1);
        xfer(0, 3'b011, 32'h8,  1'b1, 32'h00000055, 4'hF, 32'h0,        1'b1);
        xfer(0, 3'b001, 32'h3C, 1'b1, 32'h0BADF00D, 4'hF, 32'h0,        1'b0);
        for (int i = 0; i < 16; i++)
            xfer(0, 3'b001, 32'(i * 4), 1'b0, 32'h0, 4'hF, (i == 15) ? 32'h0BADF00D : 32'h0, 1'b0);
        xfer(0, 3'b010, 32'h8,  1'b0, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
        // Back-to-back alternation at 0x4
        for (int k = 0; k < 3; k++) begin
            xfer(0, 3'b100, 32'h4, 1'b1, 32'hA5A50000 + 32'(k), 4'hF, 32'h0, 1'b0);
            xfer(0, 3'b100, 32'h4, 1'b0, 32'h0, 4'hF, 32'hA5A50000 + 32'(k), 1'b0);
        end
        idle(0);

        // Three wait states
        xfer(1, 3'b100, 32'h8, 1'b1, 32'h12345678, 4'hF, 32'h0,        1'b0);
        xfer(1, 3'b100, 32'h8, 1'b0, 32'h0,        4'hF, 32'h12345678, 1'b0);
        xfer(1, 3'b001, 32'h8, 1'b0, 32'h0,        4'hF, 32'h0,        1'b0);
        xfer(1, 3'b001, 32'h4, 1'b1, 32'h000000A1, 4'hF, 32'h0,        1'b0);
        xfer(1, 3'b001, 32'h4, 1'b0, 32'h0,        4'hF, 32'h000000A1, 1'b0);
        xfer(1, 3'b010, 32'h50, 1'b0, 32'h0,       4'hF, 32'h0,        1'b1);
        idle(1);

        // Abort: drop select after one ACCESS cycle
        @(posedge clk); #1;
        psel[1] = 3'b100; pen[1] = 1'b0; pwr[1] = 1'b1; paddr[1] = 32'h8; pwdata[1] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        pen[1] = 1'b1;
        @(posedge clk); #1;
        psel[1] = 3'b000; pen[1] = 1'b0;
        @(posedge clk); #1;
        xfer(1, 3'b100, 32'h8, 1'b0, 32'h0, 4'hF, 32'h12345678, 1'b0);
        idle(1);

        // Reset in the middle of an ACCESS phase
        @(posedge clk); #1;
        psel[1] = 3'b100; pen[1] = 1'b0; pwr[1] = 1'b1; paddr[1] = 32'hC; pwdata[1] = 32'h00000077;
        @(posedge clk); #1;
        pen[1] = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; psel[1] = 3'b000; pen[1] = 1'b0;
        xfer(0, 3'b010, 32'h8, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
        idle(0);
        xfer(1, 3'b100, 32'h8, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
        xfer(1, 3'b100, 32'hC, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
        idle(1);

`ifdef APB_PSTRB_EN
        xfer(0, 3'b001, 32'h10, 1'b1, 32'h11223344, 4'hF,    32'h0,        1'b0);
        xfer(0, 3'b001, 32'h10, 1'b1, 32'hAABBCCDD, 4'b0101, 32'h0,        1'b0);
        xfer(0, 3'b001, 32'h10, 1'b0, 32'h0,        4'h0,    32'h11BB33DD, 1'b0);
        xfer(0, 3'b001, 32'h10, 1'b1, 32'hFFFFFFFF, 4'h0,    32'h0,        1'b0);
        xfer(0, 3'b001, 32'h10, 1'b0, 32'h0,        4'hF,    32'h11BB33DD, 1'b0);
        idle(0);
`endif

        repeat (4) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_completer_bank.md
Name: apb_completer_bank

Overview:
- Parametrised APB slave-side model: NUM_SLV completers, each a DEPTH-word register bank.
- Real read/write storage, programmable wait states (PREADY) and error response (PSLVERR).
- Sits behind the AHB-to-APB bridge and replaces the fixed-pattern read-data stub in system benches and FPGA bring-up.

Parameters:
- NUM_SLV, 3, number of completers; width of PSELx (one-hot).
- DATA_W, 32, PWDATA/PRDATA width; must be 32 or 64.
- ADDR_W, 32, PADDR width.
- DEPTH, 16, words per completer; power of two, 2..256.
- WAIT_STATES, 0, extra ACCESS cycles inserted before PREADY; 0..15.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSELx  in  NUM_SLV  one-hot completer select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  byte strobes (present only with APB_PSTRB_EN).
- PRDATA  out  DATA_W  read data, registered.
- PREADY  out  1  transfer-complete, registered.
- PSLVERR  out  1  error response, registered.

Behaviour:
- Clock and reset: one clock, PCLK. PRESET is synchronous and active-high; with PRESET=1 at a rising edge, everything returns to reset state.
- Reset state: state IDLE; PREADY, PSLVERR and PRDATA all 0; wait counter 0; all bank words 0.
  - Reset mid-transfer aborts the transfer; no write is committed.
- Address decode:
  - BO = log2(DATA_W/8).
  - Word index = PADDR[BO+log2(DEPTH)-1:BO]; PADDR[BO-1:0] is ignored.
  - Error if any of: PADDR >= DEPTH<<BO; PSELx not one-hot (0 or >1 bits) while in SETUP; PADDR/PWRITE/PWDATA change during ACCESS.
  - Addr, slave index, PWRITE and PWDATA are captured at the SETUP edge; the captured copy is used for the whole transfer.
- FSM states: IDLE, ACCESS.
- IDLE transitions:
  - Condition: |PSELx && !PENABLE. Action: capture request, go ACCESS, cnt<=WAIT_STATES, PREADY<=(WAIT_STATES==0).
    - If WAIT_STATES==0, also load PRDATA/PSLVERR at this edge.
  - |PSELx && PENABLE in IDLE is a protocol violation: ignored, stay IDLE, outputs stay 0.
- ACCESS transitions:
  - Transfer not complete, cnt>0: cnt<=cnt-1. When cnt==1, PREADY<=1 and PRDATA/PSLVERR are loaded.
  - Completion when PENABLE && PREADY && selected PSELx bit still high:
    - Write with no error: commit to bank[slave][word].
    - PREADY, PSLVERR and PRDATA go to 0 next cycle; go IDLE.
  - All PSELx low while in ACCESS: abort; no write; outputs go to 0; go IDLE.
- Latency: PREADY is high in ACCESS cycle number WAIT_STATES+1, counting the first PENABLE=1 cycle as 1.
  - Minimum transfer = 2 cycles (SETUP+ACCESS).
  - Back-to-back: a new SETUP may directly follow the completion cycle.
- PRDATA rules:
  - Read, no error: bank word.
  - Write, or any error: 0.
  - Outside the PREADY=1 cycle: always 0.
- PSLVERR is only ever 1 together with PREADY=1. Error writes never modify the bank.
- Banks are independent: the same word index in different completers holds separate data.

Optional Feature:
- Macro APB_PSTRB_EN.
- Defined: PSTRB port exists. Writes update only the bytes whose strobe bit is 1. PSTRB=0 on a write is a legal no-op with PSLVERR=0. PSTRB on reads is ignored.
- Not defined: no PSTRB port; every write updates the full word.

Test Plan:
- Write then read, WAIT_STATES=0, PSELx=3'b010, PADDR=0x8:
  - Write PWDATA=0xDEADBEEF → PREADY=1 in the first ACCESS cycle, PSLVERR=0.
  - Read back → PRDATA=0xDEADBEEF. Same address on PSELx=3'b001 reads 0.
- WAIT_STATES=3 read: PREADY rises exactly on the 4th PENABLE cycle and stays 0 before it; PRDATA=0 while PREADY=0.
- Out-of-range and bad select, DEPTH=16:
  - Write PADDR=0x40 → PSLVERR=1, PREADY=1, and reading 0x0..0x3C afterwards shows no change.
  - PSELx=3'b011 → PSLVERR=1.
- Abort and reset:
  - Drop PSELx mid-ACCESS with WAIT_STATES=2 → no write; FSM back in IDLE; outputs 0.
  - Assert PRESET during ACCESS → next cycle all outputs 0; previously written 0xDEADBEEF now reads 0.
- Back-to-back: alternate write/read at 0x4/0x4 with no idle cycles → each transfer takes exactly 2+WAIT_STATES cycles; read returns the just-written value.
- APB_PSTRB_EN: word=0x11223344, write 0xAABBCCDD with PSTRB=4'b0101 → reads 0x11BB33DD.
